// File: rtl/systolic_tile_engine.sv
// Output-stationary rows x cols systolic MAC tile engine with internal operand skew,
// runtime K length, signed/unsigned operands, accumulate-across-tiles and row-serial drain.
// Ports: clk/rst (sync, active high); start/k_len/acc_mode/signed_mode tile setup;
//   in_valid/in_ready + input_vec/weight_vec beat stream; out_valid/out_ready + out_row/out_row_idx
//   drain stream; busy/compute_done/cycles_count status.
module systolic_tile_engine #(
  parameter int rows     = 8,
  parameter int cols     = 8,
  parameter int ip_width = 8,
  parameter int op_width = 32,
  parameter int k_max    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(k_max+1)-1:0]        k_len,
  input  logic                              acc_mode,
  input  logic                              signed_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [rows*ip_width-1:0]          input_vec,
  input  logic [cols*ip_width-1:0]          weight_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [cols*op_width-1:0]          out_row,
  output logic [$clog2(rows)-1:0]           out_row_idx,
  output logic                              busy,
  output logic                              compute_done,
  output logic [31:0]                       cycles_count
);

  localparam int KW    = $clog2(k_max+1);
  localparam int RW    = $clog2(rows);
  localparam int FW    = $clog2(rows+cols);
  localparam int ROW_W = cols*op_width;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [FW-1:0] FLUSH_LAST = FW'(rows+cols-2);
  localparam logic [RW-1:0] LAST_ROW   = RW'(rows-1);

  logic [2:0]    state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_idx;
  logic          sm_q;

  logic accept;
  logic acc_clear;
  logic acc_en;

  assign accept       = (state == S_LOAD) && in_valid;
  assign acc_clear    = (state == S_IDLE) && start && !acc_mode;
  assign acc_en       = (state == S_LOAD) || (state == S_FLUSH);
  assign in_ready     = (state == S_LOAD);
  assign out_valid    = (state == S_DRAIN);
  assign busy         = (state == S_LOAD) || (state == S_FLUSH) || (state == S_DRAIN);
  assign compute_done = (state == S_DONE);
  assign out_row_idx  = (state == S_DRAIN) ? row_idx : '0;

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k_q          <= '0;
      sm_q         <= 1'b0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
      row_idx      <= '0;
      cycles_count <= '0;
    end else begin
      if (busy) cycles_count <= cycles_count + 32'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q          <= k_len;
            sm_q         <= signed_mode;
            cycles_count <= '0;
            beat_cnt     <= '0;
            flush_cnt    <= '0;
            row_idx      <= '0;
            state        <= (k_len == '0) ? S_DRAIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if ((beat_cnt + KW'(1)) == k_q) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FLUSH_LAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (row_idx == LAST_ROW) state <= S_DONE;
            else row_idx <= row_idx + RW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Injection: a bubble cycle (no handshake) feeds zeros so the array never stalls.
  logic [ip_width-1:0] a_inj  [rows];
  logic [ip_width-1:0] b_inj  [cols];
  logic [ip_width-1:0] a_lane [rows];
  logic [ip_width-1:0] b_lane [cols];

  always_comb begin
    for (int r = 0; r < rows; r++)
      a_inj[r] = accept ? input_vec[r*ip_width +: ip_width] : '0;
    for (int c = 0; c < cols; c++)
      b_inj[c] = accept ? weight_vec[c*ip_width +: ip_width] : '0;
  end

  // Input skew: lane r delayed r cycles
  for (genvar r = 0; r < rows; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_lane[r] = a_inj[r];
    end else begin : g_dly
      logic [ip_width-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else begin
          sr[0] <= a_inj[r];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_lane[r] = sr[r-1];
    end
  end

  // Weight skew: lane c delayed c cycles
  for (genvar c = 0; c < cols; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_lane[c] = b_inj[c];
    end else begin : g_dly
      logic [ip_width-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else begin
          sr[0] <= b_inj[c];
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_lane[c] = sr[c-1];
    end
  end

  // PE grid. Operands forward right (a) and down (b); only PEs with a neighbour keep a copy.
  logic [ip_width-1:0]        a_fwd [rows][cols-1];
  logic [ip_width-1:0]        b_fwd [rows-1][cols];
  logic [rows*ROW_W-1:0]      acc_flat;

  for (genvar r = 0; r < rows; r++) begin : g_row
    for (genvar c = 0; c < cols; c++) begin : g_col
      logic [ip_width-1:0] a_in;
      logic [ip_width-1:0] b_in;
      logic [op_width-1:0] a_ext;
      logic [op_width-1:0] b_ext;
      logic [op_width-1:0] acc;

      if (c == 0) begin : g_a_edge
        assign a_in = a_lane[r];
      end else begin : g_a_int
        assign a_in = a_fwd[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in = b_lane[c];
      end else begin : g_b_int
        assign b_in = b_fwd[r-1][c];
      end

      // Extending to op_width before multiplying gives the 2*ip_width product modulo 2^op_width.
      assign a_ext = {{(op_width-ip_width){sm_q & a_in[ip_width-1]}}, a_in};
      assign b_ext = {{(op_width-ip_width){sm_q & b_in[ip_width-1]}}, b_in};

      always_ff @(posedge clk) begin
        if (rst || acc_clear) acc <= '0;
        else if (acc_en)      acc <= acc + a_ext * b_ext;
      end
      assign acc_flat[(r*cols+c)*op_width +: op_width] = acc;

      if (c < cols-1) begin : g_a_reg
        logic [ip_width-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst) a_q <= '0;
          else     a_q <= a_in;
        end
        assign a_fwd[r][c] = a_q;
      end
      if (r < rows-1) begin : g_b_reg
        logic [ip_width-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst) b_q <= '0;
          else     b_q <= b_in;
        end
        assign b_fwd[r][c] = b_q;
      end
    end
  end

  // Drain mux; zero outside DRAIN so idle outputs read as 0
  always_comb begin
    out_row = '0;
    if (state == S_DRAIN) begin
      for (int r = 0; r < rows; r++)
        if (row_idx == RW'(r)) out_row = acc_flat[r*ROW_W +: ROW_W];
    end
  end

endmodule
